// File: rtl/button_counter_pkg.sv
// Shared types and helpers for the button_counter display front end.
// Optional feature macro used by this slice: BUTTON_COUNTER_AUTOREPEAT_EN
// (enables hold-to-repeat on the two push buttons).
package button_counter_pkg;

    // Width of the displayed binary value (one hex/BCD digit).
    localparam int CNT_W = 4;

    // Debouncer states: two settled levels plus a qualification state.
    typedef enum logic [1:0] {
        STABLE_HI = 2'd0,
        STABLE_LO = 2'd1,
        CHECK     = 2'd2
    } deb_state_t;

    // Bits needed for a counter that must hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        if (max_count < 2) begin
            return 1;
        end else begin
            return $clog2(max_count + 1);
        end
    endfunction

endpackage

// File: rtl/button_counter_debouncer.sv
// Per-input conditioning: 2-flop synchronizer, level debouncer and a
// one-cycle pulse on the asserted transition. With
// BUTTON_COUNTER_AUTOREPEAT_EN defined (and REPEAT_EN set on the instance)
// a held input also produces repeat pulses.
module debouncer
    import button_counter_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   REPEAT_DELAY    = 25000000,
    parameter int   REPEAT_PERIOD   = 10000000,
    parameter logic ACTIVE_LOW      = 1'b1,
    parameter logic REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic press
);

    // Inactive (released) level and the matching settled state.
    localparam logic       IDLE_LVL = ACTIVE_LOW;
    localparam deb_state_t IDLE_ST  = ACTIVE_LOW ? STABLE_HI : STABLE_LO;
    localparam int         DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    deb_state_t state_q;
    deb_state_t state_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic       level_q;
    logic       level_d;
    logic       press_q;
    logic       press_d;
    logic       deb_press_s;
    logic       rpt_fire_s;

    // Two-stage synchronizer; resets to the released level so no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM: a new level must persist DEBOUNCE_CYCLES samples in a row.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        deb_press_s = 1'b0;
        case (state_q)
            STABLE_HI, STABLE_LO: begin
                if (sync2_q != level_q) begin
                    // First differing sample already counts as one.
                    state_d = CHECK;
                    cnt_d   = DW'(1);
                end else begin
                    cnt_d = {DW{1'b0}};
                end
            end
            CHECK: begin
                if (sync2_q == level_q) begin
                    // Bounce: fall back and restart qualification from zero.
                    state_d = level_q ? STABLE_HI : STABLE_LO;
                    cnt_d   = {DW{1'b0}};
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = sync2_q ? STABLE_HI : STABLE_LO;
                    level_d     = sync2_q;
                    cnt_d       = {DW{1'b0}};
                    // Only the press direction produces an event.
                    deb_press_s = (sync2_q != IDLE_LVL);
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE_ST;
                level_d = IDLE_LVL;
                cnt_d   = {DW{1'b0}};
            end
        endcase
    end

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(RPT_MAX);
    localparam deb_state_t HELD_ST = ACTIVE_LOW ? STABLE_LO : STABLE_HI;
    localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_q;
    logic [RW-1:0] rpt_cnt_d;
    logic          rpt_started_q;
    logic          rpt_started_d;
    logic          held_s;

    // Repeat timer: first pulse after REPEAT_DELAY, then every REPEAT_PERIOD.
    always_comb begin
        rpt_cnt_d     = rpt_cnt_q;
        rpt_started_d = rpt_started_q;
        rpt_fire_s    = 1'b0;
        held_s        = REPEAT_EN && (state_q == HELD_ST);
        if (held_s) begin
            if (!rpt_started_q && (rpt_cnt_q == RPT_DLY_LAST)) begin
                rpt_fire_s    = 1'b1;
                rpt_cnt_d     = {RW{1'b0}};
                rpt_started_d = 1'b1;
            end else if (rpt_started_q && (rpt_cnt_q == RPT_PER_LAST)) begin
                rpt_fire_s = 1'b1;
                rpt_cnt_d  = {RW{1'b0}};
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end else begin
            // Leaving the held state (release or bounce) rearms the delay.
            rpt_cnt_d     = {RW{1'b0}};
            rpt_started_d = 1'b0;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q     <= {RW{1'b0}};
            rpt_started_q <= 1'b0;
        end else begin
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_started_q <= rpt_started_d;
        end
    end
`else
    // Repeat disabled in this build; the timing parameters only need to be sane.
    localparam logic RPT_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
    assign rpt_fire_s = REPEAT_EN & RPT_CFG_OK & 1'b0;
`endif

    // Merge debounced press and repeat events into one pulse source.
    always_comb begin
        press_d = deb_press_s | rpt_fire_s;
    end

    // FSM, counter and registered pulse output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_ST;
            cnt_q   <= {DW{1'b0}};
            level_q <= IDLE_LVL;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/button_counter.sv
// Button/switch front end for the binary-to-BCD display path: debounced
// up/down buttons and a load switch drive a 4-bit wrap-around counter.
// Optional feature macro: BUTTON_COUNTER_AUTOREPEAT_EN (hold-to-repeat).
module button_counter
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up_n,
    input  logic             btn_down_n,
    input  logic             load,
    input  logic [CNT_W-1:0] sw_value,
    output logic [CNT_W-1:0] binary,
    output logic             changed
);

    logic             up_p_s;
    logic             down_p_s;
    logic             load_p_s;
    logic [CNT_W-1:0] sw_sync1_q;
    logic [CNT_W-1:0] sw_sync2_q;
    logic [CNT_W-1:0] binary_q;
    logic [CNT_W-1:0] binary_d;
    logic             changed_q;
    logic             changed_d;

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_EN       (1'b1)
    ) u_deb_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (btn_up_n),
        .press  (up_p_s)
    );

    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_EN       (1'b1)
    ) u_deb_down (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (btn_down_n),
        .press  (down_p_s)
    );

    // The load switch is active-high and never repeats.
    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .ACTIVE_LOW      (1'b0),
        .REPEAT_EN       (1'b0)
    ) u_deb_load (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (load),
        .press  (load_p_s)
    );

    // Switch bank synchronizer; value is only consumed on a load pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q <= {CNT_W{1'b0}};
            sw_sync2_q <= {CNT_W{1'b0}};
        end else begin
            sw_sync1_q <= sw_value;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Next counter value: load beats a lone up/down; simultaneous up+down holds.
    always_comb begin
        binary_d = binary_q;
        if (load_p_s) begin
            binary_d = sw_sync2_q;
        end else if (up_p_s && !down_p_s) begin
            binary_d = binary_q + CNT_W'(1);
        end else if (down_p_s && !up_p_s) begin
            binary_d = binary_q - CNT_W'(1);
        end else begin
            binary_d = binary_q;
        end
        changed_d = (binary_d != binary_q);
    end

    // Registered outputs keep the combinational decoder input glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_q  <= {CNT_W{1'b0}};
            changed_q <= 1'b0;
        end else begin
            binary_q  <= binary_d;
            changed_q <= changed_d;
        end
    end

    assign binary  = binary_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with short debounce/repeat settings.
// Honours BUTTON_COUNTER_AUTOREPEAT_EN for the held-button expectations.
module tb_button_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_n;
    logic       btn_down_n;
    logic       load;
    logic [3:0] sw_value;
    logic [3:0] binary;
    logic       changed;

    int total  = 0;
    int passed = 0;
    int p      = 0;

    always #5 clk = ~clk;

    button_counter #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .load       (load),
        .sw_value   (sw_value),
        .binary     (binary),
        .changed    (changed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling 1 ns after each rising edge and counting pulses.
    task automatic run(input int n, inout int pulses);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (changed === 1'b1) pulses++;
        end
    endtask

    // Press the selected inputs for 10 cycles, release, let the release settle.
    task automatic press(input logic up, input logic dn, input logic ld, output int pulses);
        pulses = 0;
        if (up) btn_up_n = 1'b0;
        if (dn) btn_down_n = 1'b0;
        if (ld) load = 1'b1;
        run(10, pulses);
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        load       = 1'b0;
        run(12, pulses);
    endtask

    initial begin
        rst_n      = 1'b0;
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        load       = 1'b0;
        sw_value   = 4'd0;

        // Reset state
        run(3, p);
        check("reset_binary", 32'(binary), 32'd0);
        check("reset_changed", 32'(changed), 32'd0);
        rst_n = 1'b1;
        p = 0;
        run(20, p);
        check("idle_pulses", p, 32'd0);
        check("idle_binary", 32'(binary), 32'd0);

        // Clean press: value moves exactly 7 cycles after the pin edge
        btn_up_n = 1'b0;
        p = 0;
        run(6, p);
        check("lat_before", 32'(binary), 32'd0);
        check("lat_before_pulses", p, 32'd0);
        run(1, p);
        check("lat_binary", 32'(binary), 32'd1);
        check("lat_changed", 32'(changed), 32'd1);
        run(1, p);
        check("changed_one_cycle", 32'(changed), 32'd0);
        run(2, p);
        btn_up_n = 1'b1;
        p = 0;
        run(20, p);
        check("release_pulses", p, 32'd0);
        check("release_binary", 32'(binary), 32'd1);

        // Bounces shorter than the debounce window, then a stable low
        p = 0;
        btn_up_n = 1'b0; run(2, p);
        btn_up_n = 1'b1; run(1, p);
        btn_up_n = 1'b0; run(3, p);
        btn_up_n = 1'b1; run(1, p);
        btn_up_n = 1'b0; run(15, p);
        btn_up_n = 1'b1; run(15, p);
        check("bounce_pulses", p, 32'd1);
        check("bounce_binary", 32'(binary), 32'd2);

        // Down to 0, wrap down to 15, wrap up to 0
        press(1'b0, 1'b1, 1'b0, p);
        press(1'b0, 1'b1, 1'b0, p);
        check("down_to_zero", 32'(binary), 32'd0);
        press(1'b0, 1'b1, 1'b0, p);
        check("wrap_down_binary", 32'(binary), 32'd15);
        check("wrap_down_pulses", p, 32'd1);
        press(1'b1, 1'b0, 1'b0, p);
        check("wrap_up_binary", 32'(binary), 32'd0);
        check("wrap_up_pulses", p, 32'd1);

        // Parallel load, reload of the same value, simultaneous up+down
        sw_value = 4'b1010;
        press(1'b0, 1'b0, 1'b1, p);
        check("load_binary", 32'(binary), 32'd10);
        check("load_pulses", p, 32'd1);
        press(1'b0, 1'b0, 1'b1, p);
        check("reload_binary", 32'(binary), 32'd10);
        check("reload_pulses", p, 32'd0);
        press(1'b1, 1'b1, 1'b0, p);
        check("updown_binary", 32'(binary), 32'd10);
        check("updown_pulses", p, 32'd0);

        // Reset in the middle of an up debounce abandons the press
        btn_up_n = 1'b0;
        run(2, p);
        rst_n    = 1'b0;
        btn_up_n = 1'b1;
        run(2, p);
        check("midreset_binary", 32'(binary), 32'd0);
        rst_n = 1'b1;
        p = 0;
        run(20, p);
        check("midreset_pulses", p, 32'd0);
        check("midreset_after", 32'(binary), 32'd0);

        // Long hold from 0
        btn_up_n = 1'b0;
        p = 0;
        run(30, p);
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
        check("hold_pulses", p, 32'd7);
        check("hold_binary", 32'(binary), 32'd7);
`else
        check("hold_pulses", p, 32'd1);
        check("hold_binary", 32'(binary), 32'd1);
`endif
        btn_up_n = 1'b1;
        run(12, p);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
